mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one slow main-memory port between the I_cache and D_cache miss/writeback interfaces.
//  Sits between the two cache mem_* ports and the single external memory.
//  Grants one block transfer (128-bit line, read or write-back) at a time.
//  Each grant is held until memory returns mem_ready.
// PARAMETERS
//  ADDR_W   28   block address width (address bits [31:4])
//  DATA_W   128  line width in bits
//  RR_EN    1    1 = round-robin between I and D; 0 = fixed priority, D over I
// PORTS
//  clk          in   1       system clock, all state updates on rising edge
//  proc_reset   in   1       synchronous, active-high reset
//  mem_read_I   in   1       I_cache line-read request, held until mem_ready_I
//  mem_write_I  in   1       I_cache write request (normally tied 0)
//  mem_addr_I   in   ADDR_W  I_cache block address
//  mem_wdata_I  in   DATA_W  I_cache write line
//  mem_rdata_I  out  DATA_W  read line returned to I_cache
//  mem_ready_I  out  1       transfer complete pulse to I_cache
//  mem_read_D   in   1       D_cache line-read request
//  mem_write_D  in   1       D_cache write-back request
//  mem_addr_D   in   ADDR_W  D_cache block address
//  mem_wdata_D  in   DATA_W  D_cache write-back line
//  mem_rdata_D  out  DATA_W  read line returned to D_cache
//  mem_ready_D  out  1       transfer complete pulse to D_cache
//  mem_read     out  1       shared memory read command
//  mem_write    out  1       shared memory write command
//  mem_addr     out  ADDR_W  shared memory block address
//  mem_wdata    out  DATA_W  shared memory write line
//  mem_rdata    in   DATA_W  shared memory read line
//  mem_ready    in   1       shared memory completion, 1-cycle pulse
// BEHAVIOUR
//  State machine: IDLE, GNT_I, GNT_D, REL. State is registered; a last-granted bit (last_d) is registered.
//  Request definitions: req_I = mem_read_I|mem_write_I; req_D = mem_read_D|mem_write_D.
//  IDLE:
//   - Both requests: if RR_EN=1, grant the side not in last_d; if RR_EN=0, go to GNT_D.
//   - Single request: go to that side's GNT state.
//   - No request: stay in IDLE.
//   - The grant takes effect the cycle after the request is seen (1-cycle arbitration latency).
//  GNT_x, command path:
//   - mem_read/mem_write/mem_addr/mem_wdata = side x inputs, passed combinationally from the registered state.
//   - The other side's request is ignored; it keeps waiting.
//  GNT_x, completion:
//   - On mem_ready=1: mem_ready_x=1 in the same cycle (combinational).
//   - last_d <= (x==D); next state = REL.
//  GNT_x, abort:
//   - If req_x drops before mem_ready, go to IDLE next cycle.
//   - Memory commands fall to 0 in that same cycle; no ready is returned.
//  REL:
//   - Memory commands held 0 for exactly one cycle so the slow memory sees a deassertion.
//   - Then go to IDLE, where normal arbitration resumes.
//   - Back-to-back grants are therefore separated by REL + IDLE: 2 cycles.
//  Outside GNT:
//   - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
//   - mem_ready_I=0, mem_ready_D=0.
//   - A mem_ready arriving outside GNT is ignored.
//  Read data: mem_rdata_I and mem_rdata_D = mem_rdata at all times; it is only valid when the matching ready is 1.
//  Read and write asserted together by one side: both are forwarded unchanged (protocol error, no arbitration effect).
//  Reset (proc_reset=1 at an edge):
//   - state <= IDLE; last_d <= 1, so I wins the first tie when RR_EN=1.
//   - All outputs 0 from the next cycle.
//   - Reset mid-transfer abandons the transfer; no ready is issued.
//  Starvation: with RR_EN=1, each side waits for at most one transfer of the other side.
// TESTING
//  T1 reset: proc_reset=1 while in GNT_D with mem_read=1 -> next cycle state IDLE, mem_read=0, both ready=0.
//  T2 single I read: mem_read_I=1, addr=28'h0000040; mem_ready after 10 cycles with rdata=128'hA5..
//     -> mem_read=1, mem_addr=28'h0000040 from cycle 1; mem_ready_I=1 with rdata_I=128'hA5.. same cycle; mem_ready_D stays 0.
//  T3 simultaneous I read and D write-back, RR_EN=1, after reset -> I served first.
//     -> then D: mem_write=1, mem_wdata=mem_wdata_D, granted 2 cycles after I's ready.
//  T4 RR_EN=0, both requesting continuously for 3 transfers -> D granted every time; I never granted.
//  T5 abort: D request drops after 3 cycles of a grant -> mem_read=0 that cycle, IDLE next, no mem_ready_D.
//  T6 spurious mem_ready in IDLE or REL -> no ready pulse to either cache; state unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Block-transfer memory port: one line-sized read or write command with a completion pulse.
// The master drives commands; the slave returns read data and ready.
interface mem_arbiter_if #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
);

   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   modport master (
      output read,
      output write,
      output addr,
      output wdata,
      input  rdata,
      input  ready
   );

   modport slave (
      input  read,
      input  write,
      input  addr,
      input  wdata,
      output rdata,
      output ready
   );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one slow main-memory port between the I-cache and D-cache line interfaces,
// granting one whole block transfer at a time until memory signals completion.
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128,
   parameter bit RR_EN  = 1'b1
) (
   input  logic          clk,
   input  logic          proc_reset,
   mem_arbiter_if.slave  iCache,
   mem_arbiter_if.slave  dCache,
   mem_arbiter_if.master memory
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2,
      REL   = 2'd3
   } state_e;

   state_e            state_q;
   state_e            state_d;
   logic              lastD_q;
   logic              lastD_d;

   logic              reqI;
   logic              reqD;

   logic              cmdRead;
   logic              cmdWrite;
   logic [ADDR_W-1:0] cmdAddr;
   logic [DATA_W-1:0] cmdWdata;
   logic              readyI;
   logic              readyD;

   assign reqI = iCache.read | iCache.write;
   assign reqD = dCache.read | dCache.write;

   // lastD_q resets to 1 so that the I side wins the very first tie.
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_q <= IDLE;
         lastD_q <= 1'b1;
      end else begin
         state_q <= state_d;
         lastD_q <= lastD_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      lastD_d  = lastD_q;
      cmdRead  = 1'b0;
      cmdWrite = 1'b0;
      cmdAddr  = '0;
      cmdWdata = '0;
      readyI   = 1'b0;
      readyD   = 1'b0;

      case (state_q)
         IDLE: begin
            if (reqI && reqD) begin
               state_d = (RR_EN && lastD_q) ? GNT_I : GNT_D;
            end else if (reqI) begin
               state_d = GNT_I;
            end else if (reqD) begin
               state_d = GNT_D;
            end
         end

         // A dropped request abandons the transfer with the bus already quiet.
         GNT_I: begin
            if (!reqI) begin
               state_d = IDLE;
            end else begin
               cmdRead  = iCache.read;
               cmdWrite = iCache.write;
               cmdAddr  = iCache.addr;
               cmdWdata = iCache.wdata;
               if (memory.ready) begin
                  readyI  = 1'b1;
                  lastD_d = 1'b0;
                  state_d = REL;
               end
            end
         end

         GNT_D: begin
            if (!reqD) begin
               state_d = IDLE;
            end else begin
               cmdRead  = dCache.read;
               cmdWrite = dCache.write;
               cmdAddr  = dCache.addr;
               cmdWdata = dCache.wdata;
               if (memory.ready) begin
                  readyD  = 1'b1;
                  lastD_d = 1'b1;
                  state_d = REL;
               end
            end
         end

         REL: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign memory.read  = cmdRead;
   assign memory.write = cmdWrite;
   assign memory.addr  = cmdAddr;
   assign memory.wdata = cmdWdata;

   assign iCache.ready = readyI;
   assign dCache.ready = readyD;
   assign iCache.rdata = memory.rdata;
   assign dCache.rdata = memory.rdata;

endmodule
